// File: rtl/uart_frame_ctrl.sv
// uart_frame_ctrl: hunts SYNC_BYTE, latches a command byte and WORD_BYTES operand bytes (MSB first), presents the frame over valid/ready; UART_FRAME_CHECKSUM_EN adds a trailing XOR checksum byte
module uart_frame_ctrl #(
  parameter int WORD_BYTES = 4,
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int TIMEOUT_TICKS = 1600
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    s_tick,
  input  logic [7:0]              rx_byte,
  input  logic                    rx_done_tick,
  output logic [7:0]              cmd,
  output logic [8*WORD_BYTES-1:0] operand,
  output logic                    frame_valid,
  input  logic                    frame_ready,
  output logic                    busy,
  output logic                    err_timeout,
  output logic                    err_overrun,
  output logic                    err_chk
);
  localparam int W = 8 * WORD_BYTES;
  localparam int CW = $clog2(WORD_BYTES + 1);
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);
  typedef enum logic [2:0] {
    IDLE,
    CMD,
    DATA,
`ifdef UART_FRAME_CHECKSUM_EN
    CHK,
`endif
    HOLD
  } state_t;
  state_t state_q, state_d;
  logic [7:0] cmd_q, cmd_d;
  logic [W-1:0] operand_q, operand_d, operand_shift;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] to_q, to_d;
  logic frame_valid_q, frame_valid_d, busy_q, busy_d;
  logic err_timeout_q, err_timeout_d, err_overrun_q, err_overrun_d, err_chk_q, err_chk_d;
  logic timed, last_byte, expired;
  generate
    if (WORD_BYTES == 1) begin : g_one
      assign operand_shift = rx_byte;
    end else begin : g_many
      assign operand_shift = {operand_q[W-9:0], rx_byte};
    end
  endgenerate
`ifdef UART_FRAME_CHECKSUM_EN
  logic [7:0] chk_calc;
  // expected checksum: XOR of the command and every operand byte
  always_comb begin
    chk_calc = cmd_q;
    for (int i = 0; i < WORD_BYTES; i++) chk_calc = chk_calc ^ operand_q[8*i +: 8];
  end
`endif
  // next state, frame assembly, inter-byte timeout and error pulses
  always_comb begin
    state_d = state_q;
    cmd_d = cmd_q;
    operand_d = operand_q;
    cnt_d = cnt_q;
    err_overrun_d = 1'b0;
    err_chk_d = 1'b0;
    timed = state_q != IDLE && state_q != HOLD;
    last_byte = cnt_q == CW'(WORD_BYTES - 1);
    expired = timed && s_tick && !rx_done_tick && to_q == TW'(TIMEOUT_TICKS - 1);
    case (state_q)
      IDLE: state_d = (rx_done_tick && rx_byte == SYNC_BYTE) ? CMD : IDLE;
      CMD: if (rx_done_tick) begin
        cmd_d = rx_byte;
        operand_d = '0;
        cnt_d = '0;
        state_d = DATA;
      end
      DATA: if (rx_done_tick) begin
        operand_d = operand_shift;
        cnt_d = cnt_q + CW'(1);
`ifdef UART_FRAME_CHECKSUM_EN
        if (last_byte) state_d = CHK;
`else
        if (last_byte) state_d = HOLD;
`endif
      end
`ifdef UART_FRAME_CHECKSUM_EN
      CHK: if (rx_done_tick) begin
        state_d = (rx_byte == chk_calc) ? HOLD : IDLE;
        err_chk_d = rx_byte != chk_calc;
      end
`endif
      HOLD: if (frame_ready) state_d = (rx_done_tick && rx_byte == SYNC_BYTE) ? CMD : IDLE;
            else err_overrun_d = rx_done_tick;
      default: state_d = IDLE;
    endcase
    if (expired) state_d = IDLE;
    err_timeout_d = expired;
    to_d = (!timed || rx_done_tick || state_d != state_q) ? '0 :
           (s_tick && to_q != TW'(TIMEOUT_TICKS)) ? to_q + TW'(1) : to_q;
    frame_valid_d = state_d == HOLD;
    busy_d = state_d != IDLE;
  end
  // state and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cmd_q <= '0;
      operand_q <= '0;
      cnt_q <= '0;
      to_q <= '0;
      frame_valid_q <= 1'b0;
      busy_q <= 1'b0;
      err_timeout_q <= 1'b0;
      err_overrun_q <= 1'b0;
      err_chk_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q <= cmd_d;
      operand_q <= operand_d;
      cnt_q <= cnt_d;
      to_q <= to_d;
      frame_valid_q <= frame_valid_d;
      busy_q <= busy_d;
      err_timeout_q <= err_timeout_d;
      err_overrun_q <= err_overrun_d;
      err_chk_q <= err_chk_d;
    end
  end
  assign cmd = cmd_q;
  assign operand = operand_q;
  assign frame_valid = frame_valid_q;
  assign busy = busy_q;
  assign err_timeout = err_timeout_q;
  assign err_overrun = err_overrun_q;
  assign err_chk = err_chk_q;
endmodule

// File: tb/tb_uart_frame_ctrl.sv
// tb_uart_frame_ctrl: directed and randomized frame checks against a byte-level model of the framing rules
`timescale 1ns/1ps
module tb_uart_frame_ctrl;
  localparam int TO = 1600;
  localparam logic [7:0] SYNC = 8'hA5;
  logic clk = 1'b0, reset = 1'b1, s_tick = 1'b0, rx_done_tick = 1'b0, frame_ready = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic [7:0] cmd;
  logic [31:0] operand;
  logic frame_valid, busy, err_timeout, err_overrun, err_chk;
  int checks = 0, failures = 0;
  int n_to = 0, n_ov = 0, n_ck = 0, n_fv = 0;

  always #5 clk = ~clk;

  uart_frame_ctrl #(.WORD_BYTES(4), .SYNC_BYTE(SYNC), .TIMEOUT_TICKS(TO)) dut (
    .clk(clk), .reset(reset), .s_tick(s_tick), .rx_byte(rx_byte), .rx_done_tick(rx_done_tick),
    .cmd(cmd), .operand(operand), .frame_valid(frame_valid), .frame_ready(frame_ready),
    .busy(busy), .err_timeout(err_timeout), .err_overrun(err_overrun), .err_chk(err_chk)
  );

  // pulse and valid-cycle counters, sampled just after each edge
  always @(posedge clk) begin
    #2;
    if (!reset) begin
      if (err_timeout === 1'b1) n_to++;
      if (err_overrun === 1'b1) n_ov++;
      if (err_chk === 1'b1) n_ck++;
      if (frame_valid === 1'b1) n_fv++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within 2 ms");
    $fatal(1);
  end

  function automatic logic [7:0] csum(input logic [7:0] c, input logic [31:0] d);
    logic [7:0] x = c;
    for (int i = 0; i < 4; i++) x = x ^ d[8*i +: 8];
    return x;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    rx_byte = b;
    rx_done_tick = 1'b1;
    @(negedge clk);
    rx_done_tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    s_tick = 1'b1;
    repeat (n) @(negedge clk);
    s_tick = 1'b0;
  endtask

  task automatic send_body(input logic [7:0] c, input logic [31:0] d);
    send_byte(c);
    for (int i = 0; i < 4; i++) send_byte(d[31-8*i -: 8]);
`ifdef UART_FRAME_CHECKSUM_EN
    send_byte(csum(c, d));
`endif
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [31:0] d);
    send_byte(SYNC);
    send_body(c, d);
  endtask

  task automatic accept();
    frame_ready = 1'b1;
    @(negedge clk);
    frame_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (cmd !== 8'h00) begin failures++; $display("FAIL reset_cmd: got %h expected 00", cmd); end
    checks++; if (operand !== 32'h0) begin failures++; $display("FAIL reset_operand: got %h expected 0", operand); end
    checks++; if (frame_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", frame_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if ({err_timeout, err_overrun, err_chk} !== 3'b000) begin failures++; $display("FAIL reset_err: got %b expected 000", {err_timeout, err_overrun, err_chk}); end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_normal();
    int e0 = n_to + n_ov + n_ck;
    send_byte(SYNC);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL normal_busy_cmd: got %b expected 1", busy); end
    send_byte(8'h01);
    send_byte(8'hDE);
    send_byte(8'hAD);
    send_byte(8'hBE);
    checks++; if (frame_valid !== 1'b0) begin failures++; $display("FAIL normal_early_valid: got %b expected 0", frame_valid); end
    send_byte(8'hEF);
`ifdef UART_FRAME_CHECKSUM_EN
    send_byte(8'h23);
`endif
    checks++; if (frame_valid !== 1'b1) begin failures++; $display("FAIL normal_valid: got %b expected 1", frame_valid); end
    checks++; if (cmd !== 8'h01) begin failures++; $display("FAIL normal_cmd: got %h expected 01", cmd); end
    checks++; if (operand !== 32'hDEADBEEF) begin failures++; $display("FAIL normal_operand: got %h expected deadbeef", operand); end
    repeat (5) @(negedge clk);
    checks++; if (frame_valid !== 1'b1 || operand !== 32'hDEADBEEF) begin failures++; $display("FAIL normal_hold: got valid=%b operand=%h expected 1/deadbeef", frame_valid, operand); end
    accept();
    checks++; if (frame_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL normal_release: got valid=%b busy=%b expected 0/0", frame_valid, busy); end
    checks++; if (n_to + n_ov + n_ck !== e0) begin failures++; $display("FAIL normal_errors: got %0d expected %0d", n_to + n_ov + n_ck, e0); end
  endtask

  task automatic test_hunt();
    int e0 = n_to + n_ov + n_ck;
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h5A);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL hunt_busy: got %b expected 0", busy); end
    send_frame(8'h02, 32'h11223344);
    checks++; if (frame_valid !== 1'b1 || cmd !== 8'h02 || operand !== 32'h11223344) begin failures++; $display("FAIL hunt_frame: got valid=%b cmd=%h operand=%h expected 1/02/11223344", frame_valid, cmd, operand); end
    checks++; if (n_to + n_ov + n_ck !== e0) begin failures++; $display("FAIL hunt_errors: got %0d expected %0d", n_to + n_ov + n_ck, e0); end
    accept();
  endtask

  task automatic test_timeout();
    int t0 = n_to, f0 = n_fv;
    send_byte(SYNC);
    send_byte(8'h03);
    send_byte(8'h11);
    ticks(TO - 1);
    checks++; if (n_to !== t0 || busy !== 1'b1) begin failures++; $display("FAIL timeout_early: got pulses=%0d busy=%b expected %0d/1", n_to, busy, t0); end
    ticks(1);
    checks++; if (err_timeout !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL timeout_fire: got err=%b busy=%b expected 1/0", err_timeout, busy); end
    @(negedge clk);
    checks++; if (err_timeout !== 1'b0 || n_to !== t0 + 1) begin failures++; $display("FAIL timeout_pulse: got err=%b pulses=%0d expected 0/%0d", err_timeout, n_to, t0 + 1); end
    checks++; if (n_fv !== f0) begin failures++; $display("FAIL timeout_novalid: got %0d expected %0d", n_fv, f0); end
    send_byte(SYNC);
    send_byte(8'h03);
    ticks(TO - 1);
    s_tick = 1'b1;
    send_byte(8'h11);
    s_tick = 1'b0;
    ticks(TO - 1);
    checks++; if (n_to !== t0 + 1 || busy !== 1'b1) begin failures++; $display("FAIL timeout_byte_wins: got pulses=%0d busy=%b expected %0d/1", n_to, busy, t0 + 1); end
    ticks(1);
    checks++; if (n_to !== t0 + 2 || busy !== 1'b0) begin failures++; $display("FAIL timeout_second: got pulses=%0d busy=%b expected %0d/0", n_to, busy, t0 + 2); end
    send_frame(8'h07, 32'h55AA33CC);
    checks++; if (frame_valid !== 1'b1 || cmd !== 8'h07 || operand !== 32'h55AA33CC) begin failures++; $display("FAIL timeout_after: got valid=%b cmd=%h operand=%h expected 1/07/55aa33cc", frame_valid, cmd, operand); end
    ticks(TO + 10);
    checks++; if (frame_valid !== 1'b1 || n_to !== t0 + 2) begin failures++; $display("FAIL timeout_hold: got valid=%b pulses=%0d expected 1/%0d", frame_valid, n_to, t0 + 2); end
    accept();
  endtask

  task automatic test_overrun();
    int o0;
    send_frame(8'h08, 32'hCAFEF00D);
    o0 = n_ov;
    send_byte(8'h77);
    checks++; if (err_overrun !== 1'b1 || n_ov !== o0 + 1) begin failures++; $display("FAIL overrun_pulse: got err=%b pulses=%0d expected 1/%0d", err_overrun, n_ov, o0 + 1); end
    checks++; if (frame_valid !== 1'b1 || cmd !== 8'h08 || operand !== 32'hCAFEF00D) begin failures++; $display("FAIL overrun_keep: got valid=%b cmd=%h operand=%h expected 1/08/cafef00d", frame_valid, cmd, operand); end
    frame_ready = 1'b1;
    send_byte(SYNC);
    frame_ready = 1'b0;
    checks++; if (n_ov !== o0 + 1 || frame_valid !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL overrun_simul: got pulses=%0d valid=%b busy=%b expected %0d/0/1", n_ov, frame_valid, busy, o0 + 1); end
    send_body(8'h06, 32'h0BADC0DE);
    checks++; if (frame_valid !== 1'b1 || cmd !== 8'h06 || operand !== 32'h0BADC0DE) begin failures++; $display("FAIL overrun_next: got valid=%b cmd=%h operand=%h expected 1/06/0badc0de", frame_valid, cmd, operand); end
    accept();
  endtask

  task automatic test_reset_mid();
    int e0 = n_to + n_ov + n_ck;
    send_byte(SYNC);
    send_byte(8'h04);
    send_byte(8'hAA);
    checks++; if (cmd !== 8'h04 || operand !== 32'h000000AA) begin failures++; $display("FAIL midreset_partial: got cmd=%h operand=%h expected 04/000000aa", cmd, operand); end
    #2 reset = 1'b1;
    #1;
    checks++; if (cmd !== 8'h00 || operand !== 32'h0 || busy !== 1'b0 || frame_valid !== 1'b0) begin failures++; $display("FAIL midreset_async: got cmd=%h operand=%h busy=%b valid=%b expected zeros", cmd, operand, busy, frame_valid); end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    checks++; if (n_to + n_ov + n_ck !== e0) begin failures++; $display("FAIL midreset_errors: got %0d expected %0d", n_to + n_ov + n_ck, e0); end
    send_frame(8'h05, 32'h01020304);
    checks++; if (frame_valid !== 1'b1 || cmd !== 8'h05 || operand !== 32'h01020304) begin failures++; $display("FAIL midreset_frame: got valid=%b cmd=%h operand=%h expected 1/05/01020304", frame_valid, cmd, operand); end
    accept();
  endtask

`ifdef UART_FRAME_CHECKSUM_EN
  task automatic test_checksum();
    int c0 = n_ck, f0;
    send_byte(SYNC);
    send_byte(8'h01);
    send_byte(8'hDE);
    send_byte(8'hAD);
    send_byte(8'hBE);
    send_byte(8'hEF);
    send_byte(8'h23);
    checks++; if (frame_valid !== 1'b1 || n_ck !== c0) begin failures++; $display("FAIL chk_good: got valid=%b pulses=%0d expected 1/%0d", frame_valid, n_ck, c0); end
    accept();
    f0 = n_fv;
    send_byte(SYNC);
    send_byte(8'h01);
    send_byte(8'hDE);
    send_byte(8'hAD);
    send_byte(8'hBE);
    send_byte(8'hEF);
    send_byte(8'h24);
    checks++; if (err_chk !== 1'b1 || n_ck !== c0 + 1) begin failures++; $display("FAIL chk_bad: got err=%b pulses=%0d expected 1/%0d", err_chk, n_ck, c0 + 1); end
    @(negedge clk);
    checks++; if (n_fv !== f0 || busy !== 1'b0) begin failures++; $display("FAIL chk_bad_state: got valid_cycles=%0d busy=%b expected %0d/0", n_fv, busy, f0); end
  endtask
`else
  task automatic test_no_checksum();
    checks++; if (n_ck !== 0 || err_chk !== 1'b0) begin failures++; $display("FAIL chk_tied: got pulses=%0d err=%b expected 0/0", n_ck, err_chk); end
  endtask
`endif

  task automatic test_random();
    for (int it = 0; it < 20; it++) begin
      logic [7:0] c, g;
      logic [31:0] d, exp_op;
      int o0;
      c = 8'($urandom);
      d = $urandom;
      for (int k = 0; k < int'($urandom_range(0, 3)); k++) begin
        g = 8'($urandom);
        if (g == SYNC) g = 8'h00;
        send_byte(g);
      end
      send_byte(SYNC);
      ticks($urandom_range(0, 5));
      send_byte(c);
      exp_op = 32'h0;
      for (int i = 0; i < 4; i++) begin
        ticks($urandom_range(0, 5));
        repeat ($urandom_range(0, 2)) @(negedge clk);
        send_byte(d[31-8*i -: 8]);
        exp_op = (exp_op << 8) | 32'(d[31-8*i -: 8]);
      end
`ifdef UART_FRAME_CHECKSUM_EN
      ticks($urandom_range(0, 5));
      send_byte(csum(c, d));
`endif
      checks++; if (frame_valid !== 1'b1 || cmd !== c || operand !== exp_op) begin failures++; $display("FAIL rand_frame[%0d]: got valid=%b cmd=%h operand=%h expected 1/%h/%h", it, frame_valid, cmd, operand, c, exp_op); end
      o0 = n_ov;
      if ($urandom_range(0, 1) == 1) begin
        send_byte(8'($urandom));
        checks++; if (n_ov !== o0 + 1 || operand !== exp_op) begin failures++; $display("FAIL rand_overrun[%0d]: got pulses=%0d operand=%h expected %0d/%h", it, n_ov, operand, o0 + 1, exp_op); end
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      accept();
      checks++; if (frame_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rand_release[%0d]: got valid=%b busy=%b expected 0/0", it, frame_valid, busy); end
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_hunt();
    test_timeout();
    test_overrun();
    test_reset_mid();
`ifdef UART_FRAME_CHECKSUM_EN
    test_checksum();
`else
    test_no_checksum();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_frame_ctrl.md
Name: uart_frame_ctrl

Overview:
- Sequences the byte stream from uart_rx (dout / rx_done_tick) into framed commands for the RSA datapath.
- Hunts for a sync byte, then latches a command byte and assembles WORD_BYTES operand bytes, MSB first, into one wide word.
- Presents the frame to the RSA core over a valid/ready handshake.
- Uses s_tick from tick_generator to abort stalled frames.

Parameters:
- WORD_BYTES, 4: operand bytes per frame; legal range 1..64.
- SYNC_BYTE, 8'hA5: frame start marker.
- TIMEOUT_TICKS, 1600: s_tick pulses allowed between bytes inside a frame before abort. Default is 10 byte times at 16 ticks/bit.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- s_tick  in  1  oversample tick from tick_generator
- rx_byte  in  8  received byte (uart_rx dout)
- rx_done_tick  in  1  one-cycle strobe: rx_byte valid
- cmd  out  8  latched command byte
- operand  out  8*WORD_BYTES  assembled operand, first data byte in the MSB position
- frame_valid  out  1  frame available
- frame_ready  in  1  consumer accepts frame
- busy  out  1  high in any state other than IDLE
- err_timeout  out  1  one-cycle pulse: frame aborted by timeout
- err_overrun  out  1  one-cycle pulse: byte dropped while in HOLD
- err_chk  out  1  one-cycle pulse: checksum mismatch (tied 0 without the macro)

Behaviour:
- Reset (async, reset=1): state IDLE. cmd=0, operand=0, byte counter=0, timeout counter=0. frame_valid, busy and all err_* are 0.
- All outputs are registered. All strobes are sampled on the rising edge of clk.
- IDLE:
  - rx_done_tick with rx_byte==SYNC_BYTE -> CMD.
  - Any other byte is silently discarded.
- CMD:
  - rx_done_tick -> cmd<=rx_byte, operand<=0, byte counter<=0, go to DATA.
- DATA, on each rx_done_tick:
  - operand <= {operand[8*WORD_BYTES-9:0], rx_byte}; byte counter increments.
  - On byte WORD_BYTES: -> HOLD, or -> CHK when CHECKSUM_EN is defined.
- HOLD:
  - frame_valid=1, asserted the cycle after the rx_done_tick of the last byte.
  - cmd and operand are stable while frame_valid=1.
  - frame_valid & frame_ready -> frame_valid<=0, state IDLE.
  - frame_ready while frame_valid=0 has no effect.
- Timeout:
  - Applies in CMD, DATA and CHK.
  - The counter increments on s_tick, saturates at TIMEOUT_TICKS, and clears on every rx_done_tick and on every state entry.
  - Counter reaching TIMEOUT_TICKS -> err_timeout pulse, state IDLE, no frame_valid.
  - HOLD never times out.
  - s_tick and rx_done_tick in the same cycle: the byte wins and the counter clears.
- Overrun:
  - rx_done_tick in HOLD without a completing handshake -> byte dropped, err_overrun pulse.
  - cmd and operand are unchanged.
- Handshake and rx_done_tick in the same cycle in HOLD:
  - The handshake completes.
  - The byte is processed under IDLE rules (SYNC_BYTE -> CMD). No overrun.
- busy=1 in CMD, DATA, CHK and HOLD.
- Reset asserted mid-frame: immediate return to reset values. Partial data is lost and no error pulse is raised.

Optional Feature:
- Macro: UART_FRAME_CHECKSUM_EN.
- Defined:
  - Extra state CHK after DATA. The next byte is compared against XOR(cmd, all operand bytes).
  - Match -> HOLD.
  - Mismatch -> err_chk pulse, state IDLE, frame_valid stays 0.
- Undefined:
  - No CHK state. DATA goes directly to HOLD.
  - err_chk is constant 0.

Test Plan:
- Normal frame: bytes A5 01 DE AD BE EF, frame_ready low -> the cycle after the last strobe, frame_valid=1, cmd=01, operand=DEADBEEF, held until frame_ready=1; then IDLE, busy=0.
- Hunt: bytes 00 FF 5A, then A5 02 11 22 33 44 -> only the second sequence yields a frame: cmd=02, operand=11223344. No errors.
- Timeout: A5 03 11, then TIMEOUT_TICKS s_tick pulses with no byte -> single err_timeout pulse, IDLE, frame_valid never asserted. A following full frame is accepted normally.
- Overrun and simultaneous events:
  - Completed frame held with ready low; byte 77 arrives -> err_overrun pulse, operand unchanged.
  - Then frame_ready=1 in the same cycle as rx_done_tick with byte A5 -> no overrun, state CMD.
- Reset mid-frame: A5 04 AA, assert reset for 3 cycles -> all outputs zero immediately. Subsequent frame A5 05 01 02 03 04 -> operand=01020304.
- UART_FRAME_CHECKSUM_EN defined:
  - A5 01 DE AD BE EF with checksum 0x23 -> frame accepted.
  - Same frame with checksum 0x24 -> err_chk pulse, no frame_valid.
